// File: rtl/counter_sequencer.sv
// Sequencer for an external up counter: prescaled count enable, terminal-count
// detection, one-shot or wrapping run, and start/stop/pause/clear handling.
module counter_sequencer #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  mode,
  input  logic [WIDTH-1:0]      term_val,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [WIDTH-1:0]      cnt_q,
  output logic                  cnt_en,
  output logic                  cnt_clr,
  output logic                  busy,
  output logic                  done,
  output logic                  wrap,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t                cur, nxt;
  logic [PRESCALE_W-1:0] pre_cnt, pre_nxt, pre_lat;
  logic [WIDTH-1:0]      term_lat;
  logic                  mode_lat;
  logic                  latch, tick, en_c, clr_c, done_nxt, wrap_nxt;

  assign tick = (cur == RUN) && (pre_cnt == pre_lat);

  always_comb begin
    nxt      = cur;
    pre_nxt  = pre_cnt;
    latch    = 1'b0;
    en_c     = 1'b0;
    clr_c    = 1'b0;
    done_nxt = 1'b0;
    wrap_nxt = 1'b0;
    if (clear) begin
      clr_c   = 1'b1;
      pre_nxt = '0;
      nxt     = IDLE;
    end else begin
      case (cur)
        IDLE, DONE: begin
          pre_nxt = '0;
          if (start) begin
            latch = 1'b1;
            clr_c = 1'b1;
            nxt   = RUN;
          end
        end
        RUN: begin
          // A stop cycle freezes the prescaler so the paused phase resumes exactly.
          if (stop) begin
            nxt = PAUSE;
          end else if (tick) begin
            pre_nxt = '0;
            if (cnt_q != term_lat) begin
              en_c = 1'b1;
            end else if (mode_lat) begin
              clr_c    = 1'b1;
              wrap_nxt = 1'b1;
            end else begin
              done_nxt = 1'b1;
              nxt      = DONE;
            end
          end else begin
            pre_nxt = pre_cnt + 1'b1;
          end
        end
        PAUSE: begin
          if (start) nxt = RUN;
        end
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur      <= IDLE;
      pre_cnt  <= '0;
      pre_lat  <= '0;
      term_lat <= '0;
      mode_lat <= 1'b0;
      done     <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      cur     <= nxt;
      pre_cnt <= pre_nxt;
      done    <= done_nxt;
      wrap    <= wrap_nxt;
      if (latch) begin
        pre_lat  <= prescale;
        term_lat <= term_val;
        mode_lat <= mode;
      end
    end
  end

  // Commands arriving during reset must not reach the counter.
  assign cnt_en  = en_c  & ~reset;
  assign cnt_clr = clr_c & ~reset;
  assign busy    = (cur == RUN) || (cur == PAUSE);
  assign state   = cur;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: directed scenarios plus random commands checked
// against an elapsed-cycle reference model driving a behavioural counter.
module tb_counter_sequencer;
  localparam int WIDTH = 4;
  localparam int PW    = 8;

  logic             clk = 1'b0, reset = 1'b1;
  logic             start = 1'b0, stop = 1'b0, clear = 1'b0, mode = 1'b0;
  logic [WIDTH-1:0] term_val = '0, cnt_q, cnt;
  logic [PW-1:0]    prescale = '0;
  logic             cnt_en, cnt_clr, busy, done, wrap;
  logic [1:0]       state;
  int               n_checks = 0, n_err = 0;

  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(WIDTH), .PRESCALE_W(PW)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .mode(mode), .term_val(term_val), .prescale(prescale), .cnt_q(cnt_q),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr), .busy(busy), .done(done),
    .wrap(wrap), .state(state)
  );

  // The controlled counter, clear has priority over enable.
  always @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else if (cnt_en) cnt <= cnt + 1'b1;
  assign cnt_q = cnt;

  // Reference model: 0=IDLE 1=RUN 2=PAUSE 3=DONE; ticks derived from the number
  // of active run cycles since launch rather than a prescaler register.
  int   m_state, m_act, m_pre, m_term, m_cnt;
  logic m_mode, m_done, m_wrap, m_tick, m_en, m_clr;

  always_comb begin
    m_tick = (m_state == 1) && (((m_act + 1) % (m_pre + 1)) == 0);
    m_en   = 1'b0;
    m_clr  = 1'b0;
    if (!reset) begin
      if (clear) m_clr = 1'b1;
      else if ((m_state == 0 || m_state == 3) && start) m_clr = 1'b1;
      else if (m_state == 1 && !stop && m_tick) begin
        if (m_cnt != m_term) m_en = 1'b1;
        else if (m_mode) m_clr = 1'b1;
      end
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state <= 0; m_act <= 0; m_pre <= 0; m_term <= 0; m_cnt <= 0;
      m_mode <= 1'b0; m_done <= 1'b0; m_wrap <= 1'b0;
    end else begin
      m_done <= 1'b0;
      m_wrap <= 1'b0;
      m_cnt  <= m_clr ? 0 : (m_en ? (m_cnt + 1) % 16 : m_cnt);
      if (clear) begin
        m_state <= 0; m_act <= 0;
      end else begin
        case (m_state)
          0, 3: if (start) begin
            m_state <= 1; m_act <= 0;
            m_mode <= mode; m_term <= int'(term_val); m_pre <= int'(prescale);
          end
          1: if (stop) m_state <= 2;
             else begin
               m_act <= m_act + 1;
               if (m_tick && m_cnt == m_term) begin
                 if (m_mode) m_wrap <= 1'b1;
                 else begin m_done <= 1'b1; m_state <= 3; end
               end
             end
          2: if (start) m_state <= 1;
          default: ;
        endcase
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; clear = 1'b1;
    #1;
    n_checks++;
    if ({state, cnt_en, cnt_clr, busy, done, wrap} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected 0000000", {state, cnt_en, cnt_clr, busy, done, wrap});
    end
    do_reset();
  endtask

  task automatic test_oneshot();
    int en_n = 0, done_n = 0, done_at = -1;
    logic clr0;
    do_reset();
    @(negedge clk); mode = 1'b0; term_val = 4'd3; prescale = 8'd0; start = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) begin @(negedge clk); start = 1'b0; end
      #1;
      if (k == 0) clr0 = cnt_clr;
      if (cnt_en) en_n++;
      if (done) begin done_n++; if (done_at < 0) done_at = k; end
    end
    n_checks++; if (clr0 !== 1'b1) begin n_err++; $display("FAIL oneshot_launch_clr: got %b expected 1", clr0); end
    n_checks++; if (en_n != 3) begin n_err++; $display("FAIL oneshot_en_count: got %0d expected 3", en_n); end
    n_checks++; if (done_at != 5 || done_n != 1) begin n_err++; $display("FAIL oneshot_done: at %0d x%0d expected at 5 x1", done_at, done_n); end
    n_checks++; if (state !== 2'b11 || cnt_q !== 4'd3) begin n_err++; $display("FAIL oneshot_final: state %0d cnt %0d expected 3/3", state, cnt_q); end
  endtask

  task automatic test_continuous();
    int en_n = 0, wrap_n = 0, first = -1, last = -1, gap_bad = 0, done_n = 0;
    do_reset();
    @(negedge clk); mode = 1'b1; term_val = 4'd2; prescale = 8'd2; start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin @(negedge clk); start = 1'b0; end
      if (k == 5) term_val = 4'd7;  // must not affect the running sequence
      #1;
      if (cnt_en) en_n++;
      if (done) done_n++;
      if (wrap) begin
        wrap_n++;
        if (first < 0) first = k;
        else if (k - last != 9) gap_bad++;
        last = k;
      end
    end
    n_checks++; if (wrap_n != 4 || first != 10 || gap_bad != 0) begin n_err++; $display("FAIL cont_wrap: n=%0d first=%0d badgaps=%0d expected 4/10/0", wrap_n, first, gap_bad); end
    n_checks++; if (en_n != 9) begin n_err++; $display("FAIL cont_en_count: got %0d expected 9", en_n); end
    n_checks++; if (done_n != 0 || state !== 2'b01) begin n_err++; $display("FAIL cont_state: done=%0d state=%0d expected 0/1", done_n, state); end
  endtask

  task automatic test_pause();
    int active = 0;
    logic stopped = 1'b0, got_done = 1'b0;
    do_reset();
    @(negedge clk); mode = 1'b0; term_val = 4'd5; prescale = 8'd1; start = 1'b1;
    for (int k = 1; k < 40 && !stopped; k++) begin
      @(negedge clk); start = 1'b0; #1;
      if (cnt_q == 4'd2) begin stop = 1'b1; stopped = 1'b1; end
      else if (state == 2'b01) active++;
    end
    n_checks++; if (!stopped) begin n_err++; $display("FAIL pause_reach2: timeout cnt=%0d expected 2", cnt_q); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); stop = 1'b0; #1;
      n_checks++;
      if ({state, cnt_q, cnt_en} !== {2'b10, 4'd2, 1'b0}) begin
        n_err++; $display("FAIL pause_hold: state %0d cnt %0d en %b expected 2/2/0", state, cnt_q, cnt_en);
      end
    end
    @(negedge clk); start = 1'b1; #1;
    for (int k = 0; k < 40 && !got_done; k++) begin
      @(negedge clk); start = 1'b0; #1;
      if (done) got_done = 1'b1;
      else if (state == 2'b01) active++;
    end
    n_checks++; if (!got_done || active != 12 || cnt_q !== 4'd5) begin n_err++; $display("FAIL pause_resume: done=%b active=%0d cnt=%0d expected 1/12/5", got_done, active, cnt_q); end
  endtask

  task automatic test_clear();
    logic found;
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      found = 1'b0;
      @(negedge clk); mode = 1'b0; term_val = 4'd9; prescale = 8'd0; start = 1'b1;
      for (int k = 0; k < 20 && !found; k++) begin
        @(negedge clk); start = 1'b0; #1;
        if (cnt_q == 4'd4) found = 1'b1;
      end
      clear = 1'b1;
      if (rep == 1) begin start = 1'b1; stop = 1'b1; end
      #1;
      n_checks++; if (!found || cnt_clr !== 1'b1 || cnt_en !== 1'b0) begin n_err++; $display("FAIL clear_cycle%0d: found=%b clr=%b en=%b expected 1/1/0", rep, found, cnt_clr, cnt_en); end
      @(negedge clk); clear = 1'b0; start = 1'b0; stop = 1'b0; #1;
      n_checks++; if ({state, cnt_q, done, wrap} !== 8'b0) begin n_err++; $display("FAIL clear_after%0d: state %0d cnt %0d done %b wrap %b expected all 0", rep, state, cnt_q, done, wrap); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk); mode = 1'b1; term_val = 4'd15; prescale = 8'd0; start = 1'b1;
    repeat (5) begin @(negedge clk); start = 1'b0; end
    @(posedge clk); #2; reset = 1'b1; start = 1'b1; clear = 1'b1; #1;
    n_checks++;
    if ({state, cnt_en, cnt_clr, done, wrap, busy, cnt_q} !== 11'b0) begin
      n_err++; $display("FAIL async_reset: state %0d en %b clr %b done %b wrap %b busy %b cnt %0d expected all 0",
                        state, cnt_en, cnt_clr, done, wrap, busy, cnt_q);
    end
    @(negedge clk); reset = 1'b0; clear = 1'b0; #1;
    n_checks++; if (cnt_clr !== 1'b1) begin n_err++; $display("FAIL relaunch_clr: got %b expected 1", cnt_clr); end
    repeat (4) @(negedge clk);
    #1;
    n_checks++; if (state !== 2'b01 || cnt_q !== 4'd3) begin n_err++; $display("FAIL relaunch_held_start: state %0d cnt %0d expected 1/3", state, cnt_q); end
    start = 1'b0;
  endtask

  task automatic test_term_zero();
    int en_n = 0, done_at = -1;
    do_reset();
    @(negedge clk); mode = 1'b0; term_val = 4'd0; prescale = 8'd4; start = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) begin @(negedge clk); start = 1'b0; end
      #1;
      if (cnt_en) en_n++;
      if (done && done_at < 0) done_at = k;
    end
    n_checks++; if (en_n != 0 || done_at != 6) begin n_err++; $display("FAIL term0: en=%0d done_at=%0d expected 0/6", en_n, done_at); end
    n_checks++; if (cnt_q !== 4'd0 || state !== 2'b11) begin n_err++; $display("FAIL term0_final: cnt %0d state %0d expected 0/3", cnt_q, state); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start    = ($urandom_range(0, 3) == 0);
      stop     = ($urandom_range(0, 9) == 0);
      clear    = ($urandom_range(0, 29) == 0);
      mode     = 1'($urandom_range(0, 1));
      term_val = 4'($urandom_range(0, 15));
      prescale = 8'($urandom_range(0, 3));
      #1;
      n_checks++;
      if (cnt_en !== m_en || cnt_clr !== m_clr) begin
        n_err++; $display("FAIL rand_en_clr @%0d: en %b clr %b expected %b %b", i, cnt_en, cnt_clr, m_en, m_clr);
      end
      n_checks++;
      if (state !== 2'(m_state) || busy !== (m_state == 1 || m_state == 2)) begin
        n_err++; $display("FAIL rand_state @%0d: state %0d busy %b expected %0d", i, state, busy, m_state);
      end
      n_checks++;
      if (done !== m_done || wrap !== m_wrap || int'(cnt_q) != m_cnt) begin
        n_err++; $display("FAIL rand_pulse_cnt @%0d: done %b wrap %b cnt %0d expected %b %b %0d", i, done, wrap, cnt_q, m_done, m_wrap, m_cnt);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_oneshot();
    test_continuous();
    test_pause();
    test_clear();
    test_async_reset();
    test_term_zero();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
